// File: rtl/timer_ctrl.sv
// timer_ctrl: sequencing FSM for the counter_mod10 countdown chain.
// Turns keypad/door events into load/clear strobes for the counters and
// divides the clock into countdown ticks while the oven is running.
module timer_ctrl #(
    parameter int TICK_DIV = 100,
    parameter int PW       = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_req,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    input  logic       counters_zero,
    output logic       loadn,
    output logic       clearn,
    output logic       enable,
    output logic       heater_on,
    output logic       done,
    output logic [2:0] state_o
);

    localparam logic [2:0]    S_IDLE     = 3'd0;
    localparam logic [2:0]    S_RUN      = 3'd1;
    localparam logic [2:0]    S_PAUSE    = 3'd2;
    localparam logic [2:0]    S_DONE     = 3'd3;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [2:0]    r_state;
    logic [PW-1:0] r_presc;
    logic          r_loadn;
    logic          r_clearn;
    logic          r_enable;
    logic          r_heater;
    logic          r_done;
    logic [2:0]    r_state_o;

    logic [2:0]    w_next_state;
    logic [PW-1:0] w_next_presc;
    logic          w_hold;
    logic          w_loadn_d;
    logic          w_clearn_d;
    logic          w_enable_d;

    // Pause request: explicit stop key or the door being opened.
    assign w_hold = stop | ~door_closed;

    // State, prescaler and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_loadn   <= 1'b1;
            r_clearn  <= 1'b1;
            r_enable  <= 1'b0;
            r_heater  <= 1'b0;
            r_done    <= 1'b0;
            r_state_o <= S_IDLE;
        end else begin
            r_state   <= w_next_state;
            r_presc   <= w_next_presc;
            r_loadn   <= w_loadn_d;
            r_clearn  <= w_clearn_d;
            r_enable  <= w_enable_d;
            r_heater  <= (w_next_state == S_RUN);
            r_done    <= (w_next_state == S_DONE);
            r_state_o <= w_next_state;
        end
    end

    // Next phase and prescaler; priority is clear, then pause request, then start/zero.
    always_comb begin
        w_next_state = r_state;
        w_next_presc = r_presc;
        case (r_state)
            S_IDLE: begin
                w_next_presc = '0;
                if (!clear && !w_hold && start && !counters_zero) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (clear) begin
                    w_next_state = S_IDLE;
                    w_next_presc = '0;
                end else if (w_hold) begin
                    // Prescaler frozen so a resume continues the partial tick.
                    w_next_state = S_PAUSE;
                end else if (counters_zero) begin
                    w_next_state = S_DONE;
                end else if (r_presc == PRESC_LAST) begin
                    w_next_presc = '0;
                end else begin
                    w_next_presc = r_presc + PW'(1);
                end
            end
            S_PAUSE: begin
                if (clear) begin
                    w_next_state = S_IDLE;
                    w_next_presc = '0;
                end else if (start && door_closed && !stop) begin
                    w_next_state = S_RUN;
                end
            end
            S_DONE: begin
                if (clear || stop) begin
                    w_next_state = S_IDLE;
                    w_next_presc = '0;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_presc = '0;
            end
        endcase
    end

    // Strobe generation; a held key re-arms only after the strobe has been high for a cycle.
    always_comb begin
        w_loadn_d  = 1'b1;
        w_clearn_d = 1'b1;
        w_enable_d = 1'b0;
        if (clear || (r_state == S_DONE && stop)) begin
            w_clearn_d = ~r_clearn;
        end else if (r_state == S_IDLE && w_next_state == S_IDLE && !w_hold && load_req) begin
            w_loadn_d = ~r_loadn;
        end
        // Tick only when staying in RUN, so stop, clear and zero all suppress it.
        if (r_state == S_RUN && w_next_state == S_RUN && r_presc == PRESC_LAST && !counters_zero) begin
            w_enable_d = 1'b1;
        end
    end

    assign loadn     = r_loadn;
    assign clearn    = r_clearn;
    assign enable    = r_enable;
    assign heater_on = r_heater;
    assign done      = r_done;
    assign state_o   = r_state_o;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed key/door sequences, a cycle model of the
// oven phases and tick timer, and literal timing checks from hand analysis.
module tb_timer_ctrl;

    localparam int TICK_DIV = 4;
    localparam int PW       = 16;

    logic       clock;
    logic       reset;
    logic       load_req;
    logic       start;
    logic       stop;
    logic       clear;
    logic       door_closed;
    logic       counters_zero;
    logic       loadn;
    logic       clearn;
    logic       enable;
    logic       heater_on;
    logic       done;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    timer_ctrl #(.TICK_DIV(TICK_DIV), .PW(PW)) dut (
        .clock         (clock),
        .reset         (reset),
        .load_req      (load_req),
        .start         (start),
        .stop          (stop),
        .clear         (clear),
        .door_closed   (door_closed),
        .counters_zero (counters_zero),
        .loadn         (loadn),
        .clearn        (clearn),
        .enable        (enable),
        .heater_on     (heater_on),
        .done          (done),
        .state_o       (state_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model state: phase (0 idle, 1 run, 2 pause, 3 done), cycles elapsed in
    // the current tick period, and the expected strobe levels.
    typedef struct packed {
        logic [1:0]  ph;
        logic [15:0] elapsed;
        logic        ld_n;
        logic        clr_n;
        logic        en;
    } mstate_t;

    mstate_t m;
    logic    m_valid = 1'b0;

    function automatic mstate_t model_step(input mstate_t s, input logic rst,
                                           input logic ld, input logic st, input logic sp,
                                           input logic cl, input logic dc, input logic zr);
        mstate_t n;
        logic    pause_req;
        int      el;
        n         = s;
        n.ld_n    = 1'b1;
        n.clr_n   = 1'b1;
        n.en      = 1'b0;
        pause_req = sp || !dc;
        el        = int'(s.elapsed);
        if (rst) begin
            n.ph      = 2'd0;
            n.elapsed = '0;
            return n;
        end
        case (s.ph)
            2'd0: begin
                el = 0;
                if (cl) n.clr_n = !s.clr_n;
                else if (pause_req) ;
                else if (st && !zr) n.ph = 2'd1;
                else if (ld) n.ld_n = !s.ld_n;
            end
            2'd1: begin
                if (cl) begin n.ph = 2'd0; n.clr_n = 1'b0; el = 0; end
                else if (pause_req) n.ph = 2'd2;
                else if (zr) n.ph = 2'd3;
                else begin
                    el = el + 1;
                    if (el == TICK_DIV) begin el = 0; n.en = 1'b1; end
                end
            end
            2'd2: begin
                if (cl) begin n.ph = 2'd0; n.clr_n = 1'b0; el = 0; end
                else if (st && dc && !sp) n.ph = 2'd1;
            end
            default: begin
                if (cl || sp) begin n.ph = 2'd0; n.clr_n = 1'b0; el = 0; end
            end
        endcase
        n.elapsed = 16'(el);
        return n;
    endfunction

    always @(posedge clock) begin
        m <= model_step(m, reset, load_req, start, stop, clear, door_closed, counters_zero);
        if (reset) m_valid <= 1'b1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model plus strobe exclusivity.
    initial begin
        forever begin
            @(negedge clock);
            if (m_valid) begin
                chk("m_loadn",   16'(loadn),     16'(m.ld_n));
                chk("m_clearn",  16'(clearn),    16'(m.clr_n));
                chk("m_enable",  16'(enable),    16'(m.en));
                chk("m_heater",  16'(heater_on), 16'(m.ph == 2'd1));
                chk("m_done",    16'(done),      16'(m.ph == 2'd3));
                chk("m_state",   16'(state_o),   16'({1'b0, m.ph}));
                chk("excl_load_en",  16'(!loadn && enable),  16'(0));
                chk("excl_load_clr", 16'(!loadn && !clearn), 16'(0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; load_req = 1'b0; start = 1'b0; stop = 1'b0;
        clear = 1'b0; door_closed = 1'b1; counters_zero = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_loadn", 16'(loadn), 16'(1));
        chk("rst_clearn", 16'(clearn), 16'(1));
        chk("rst_enable", 16'(enable), 16'(0));
        chk("rst_heater", 16'(heater_on), 16'(0));
        chk("rst_done", 16'(done), 16'(0));
        chk("rst_state", 16'(state_o), 16'(0));

        // Single load request, then a held one giving alternate pulses.
        reset = 1'b0; load_req = 1'b1;
        @(negedge clock); load_req = 1'b0;
        chk("load_pulse", 16'(loadn), 16'(0));
        chk("load_state", 16'(state_o), 16'(0));
        @(negedge clock);
        chk("load_end", 16'(loadn), 16'(1));
        load_req = 1'b1;
        @(negedge clock); chk("held_a", 16'(loadn), 16'(0));
        @(negedge clock); chk("held_b", 16'(loadn), 16'(1));
        @(negedge clock); chk("held_c", 16'(loadn), 16'(0));
        load_req = 1'b0;
        @(negedge clock);

        // Countdown: pulses 4, 8, 12 cycles after entry, then zero -> DONE.
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        chk("cd_entry", 16'(state_o), 16'(1));
        chk("cd_heater", 16'(heater_on), 16'(1));
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            chk("cd_enable", 16'(enable), (i % 4 == 0) ? 16'(1) : 16'(0));
        end
        counters_zero = 1'b1;
        @(negedge clock);
        chk("cd_done", 16'(done), 16'(1));
        chk("cd_heater_off", 16'(heater_on), 16'(0));
        chk("cd_state", 16'(state_o), 16'(3));
        chk("cd_no4th", 16'(enable), 16'(0));
        @(negedge clock);
        chk("cd_no4th_b", 16'(enable), 16'(0));

        // Clear from DONE.
        clear = 1'b1;
        @(negedge clock); clear = 1'b0; counters_zero = 1'b0;
        chk("clr_done_n", 16'(clearn), 16'(0));
        chk("clr_done_st", 16'(state_o), 16'(0));
        @(negedge clock);
        chk("clr_done_end", 16'(clearn), 16'(1));

        // Door opened after the first pulse; prescaler held at 1 across the pause,
        // so after resume the cycles run with prescaler 1, 2, 3 and the pulse shows on the third.
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        chk("door_entry", 16'(state_o), 16'(1));
        repeat (4) @(negedge clock);
        chk("door_p1", 16'(enable), 16'(1));
        @(negedge clock); door_closed = 1'b0;
        @(negedge clock);
        chk("door_pause", 16'(state_o), 16'(2));
        chk("door_heater", 16'(heater_on), 16'(0));
        door_closed = 1'b1;
        @(negedge clock);
        chk("door_still_pause", 16'(state_o), 16'(2));
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        chk("door_resume", 16'(state_o), 16'(1));
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            chk("door_p2", 16'(enable), (i == 3) ? 16'(1) : 16'(0));
        end

        // Clear from RUN.
        clear = 1'b1;
        @(negedge clock); clear = 1'b0;
        chk("clr_run_n", 16'(clearn), 16'(0));
        chk("clr_run_st", 16'(state_o), 16'(0));
        chk("clr_run_heat", 16'(heater_on), 16'(0));
        @(negedge clock);
        chk("clr_run_end", 16'(clearn), 16'(1));

        // Stop then clear from PAUSE.
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        stop = 1'b1;
        @(negedge clock); stop = 1'b0;
        chk("stop_pause", 16'(state_o), 16'(2));
        clear = 1'b1;
        @(negedge clock); clear = 1'b0;
        chk("clr_pause_n", 16'(clearn), 16'(0));
        chk("clr_pause_st", 16'(state_o), 16'(0));
        @(negedge clock);

        // Stop on the wrap edge beats the tick.
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (3) @(negedge clock);
        stop = 1'b1;
        @(negedge clock); stop = 1'b0;
        chk("stopwrap_en", 16'(enable), 16'(0));
        chk("stopwrap_st", 16'(state_o), 16'(2));
        clear = 1'b1;
        @(negedge clock); clear = 1'b0;
        @(negedge clock);

        // Start with zero loaded is ignored.
        counters_zero = 1'b1; start = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("zero_state", 16'(state_o), 16'(0));
            chk("zero_enable", 16'(enable), 16'(0));
            chk("zero_heater", 16'(heater_on), 16'(0));
        end
        start = 1'b0; counters_zero = 1'b0;
        @(negedge clock);

        // Clear and start together in IDLE.
        clear = 1'b1; start = 1'b1;
        @(negedge clock); clear = 1'b0; start = 1'b0;
        chk("clrstart_n", 16'(clearn), 16'(0));
        chk("clrstart_st", 16'(state_o), 16'(0));
        @(negedge clock);
        chk("clrstart_end", 16'(clearn), 16'(1));
        chk("clrstart_st2", 16'(state_o), 16'(0));

        // Reset on the prescaler-wrap edge.
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        chk("rstrun_en", 16'(enable), 16'(0));
        chk("rstrun_st", 16'(state_o), 16'(0));
        chk("rstrun_clrn", 16'(clearn), 16'(1));
        chk("rstrun_heat", 16'(heater_on), 16'(0));
        @(negedge clock);
        chk("rstrun_en2", 16'(enable), 16'(0));

        // Stop leaves DONE with a clear strobe.
        start = 1'b1;
        @(negedge clock); start = 1'b0; counters_zero = 1'b1;
        @(negedge clock);
        chk("stopdone_done", 16'(done), 16'(1));
        stop = 1'b1;
        @(negedge clock); stop = 1'b0; counters_zero = 1'b0;
        chk("stopdone_n", 16'(clearn), 16'(0));
        chk("stopdone_st", 16'(state_o), 16'(0));

        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
